dram_burst_reader: RTL and testbench
====================================

# dram_burst_reader

Sequential DRAM read master for the accelerator's off-chip DRAM port: the reading counterpart of the output writer that stores result maps at word address 0x180000 and up. Given a base word address and a length, it drives the multiplexed RAS/CAS DRAM interface (`CSn`/`RASn`/`CASn`/`WEn`/`A`/`D`/`Q`) in page mode. It returns the words in order on a valid/ready stream, buffered in a small FIFO. It feeds readback, pooling and next-layer input loaders.

## Interface
- `TRCD`, 2: cycles from the activate cycle to the first CAS.
- `CL`, 2: cycles from the CAS cycle to `Q` valid.
- `TRP`, 2: cycles `RASn` is held high for precharge before the next activate.
- `FIFO_DEPTH`, 8: output buffer depth (power of 2, ≥ CL+1).
- `clk`  in  1  clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request pulse; sampled only when `busy`=0.
- `base_addr`  in  23  word address = {row[12:0], col[9:0]}; sampled with `start`.
- `length`  in  23  word count; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last word is handed off.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts the word when `out_valid` and `out_ready` are both high.
- `out_data`  out  32  FIFO head.
- `Q`  in  32  DRAM read data.
- `CSn`, `RASn`, `CASn`  out  1 each  DRAM strobes, active-low.
- `WEn`  out  4  held at 4'hF (reads only).
- `A`  out  13  row or column address (column zero-extended from 10 bits).
- `D`  out  32  held at 0.

## Operation
- States: IDLE, ACT, RCD, READ, PRE, DRAIN.
- **IDLE**
  - `start`, `length`≠0 → latch row, col and remaining count; go to ACT.
  - `start`, `length`=0 → pulse `done` next cycle; no DRAM activity.
- **ACT** (1 cycle): `CSn`=0, `RASn`=0, `A`=row. Go to RCD.
- **RCD**: hold `RASn`=0 for TRCD−1 cycles, then go to READ.
- **READ**
  - Each cycle, issue one CAS (`CASn`=0, `A`=col) if remaining>0 and credit is available.
  - Credit = FIFO occupancy + in-flight reads < FIFO_DEPTH.
  - After a CAS: col+1, remaining−1.
  - If no credit: `CASn`=1, `RASn` stays low (row kept open).
- **Row end**: after the CAS at col=1023, col wraps to 0 and row increments.
  - remaining>0 → PRE, then ACT.
  - remaining=0 → PRE, then DRAIN.
- **PRE**: `RASn`=1, `CSn`=0 for TRP cycles.
- **DRAIN**: `CSn`=1. Wait until in-flight=0 and FIFO empty, then pulse `done` and go to IDLE.
- **Capture**: an in-flight shift register of depth CL tags each CAS; the tagged `Q` is pushed into the FIFO CL cycles later. A push and a pop may occur in the same cycle.
- `start` while `busy` is ignored. Row 8191 wrapping to 0 is not checked.
- **Reset** (`rst`=0, any state): returns to IDLE; FIFO and in-flight tags are flushed.

## Timing
- **Reset values**: `CSn`=`RASn`=`CASn`=1, `WEn`=4'hF, `A`=0, `D`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0.
- All DRAM outputs are registered.
- **First-word latency**: ACT in the cycle after `start`, CAS TRCD cycles later, `out_valid` CL+1 cycles after the CAS.
- **Throughput**: one word per cycle within a row while `out_ready`=1.
- **Row-change penalty**: 1 (PRE entry) + TRP + 1 (ACT) + TRCD cycles.
- `done` rises the cycle after the final handshake; `busy` falls in the same cycle.
- A full FIFO never overflows; the credit rule guarantees it.

## Structure
- **Shared package** `dram_pkg`:
  - `ROW_W`=13, `COL_W`=10, `ADDR_W`=23.
  - State enum `rd_state_e`.
  - Constants `OUTPUT_START`=23'h180000, `WEIGHT_START`=23'h100000.
- **Sub-module** `dram_rd_fifo`: synchronous FIFO with count output and async active-low reset.

## Test plan
- **Basic burst**: `base_addr`=0x180000, `length`=4, `out_ready`=1 → ACT with `A`=0x600. TRCD cycles later, CAS on 4 consecutive cycles with `A`=0,1,2,3. Words 0x180000–0x180003 appear in order; `done` one cycle after the 4th handshake.
- **Row crossing**: `base_addr`={row 5, col 1022}, `length`=4 → CAS at cols 1022, 1023; `RASn` high for exactly 2 cycles; ACT with `A`=6; CAS at cols 0, 1. Four words in order.
- **Backpressure**: `FIFO_DEPTH`=4, `length`=10, `out_ready`=0 → exactly 4 CAS, then stall with `RASn` still low. Raising `out_ready` resumes the reads; all 10 words arrive in order with none lost or duplicated.
- **Zero length**: `length`=0 → `done` one cycle after `start`; `CSn` stays 1 throughout.
- **Reset mid-burst**: assert `rst`=0 in READ → all outputs take reset values immediately. A following `start` with `length`=2 completes correctly with no stale FIFO data.
- **Start while busy**: second `start` pulse during a burst → ignored; exactly one `done` for the first request.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and constants for the accelerator's off-chip DRAM masters.
package dram_pkg;

  localparam int unsigned ROW_W  = 13;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ADDR_W = 23;

  localparam logic [ADDR_W-1:0] OUTPUT_START = 23'h180000;
  localparam logic [ADDR_W-1:0] WEIGHT_START = 23'h100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACT,
    ST_RCD,
    ST_READ,
    ST_PRE,
    ST_DRAIN
  } rd_state_e;

  // Strobes and address as driven on the multiplexed DRAM pins.
  typedef struct packed {
    logic             cs_n;
    logic             ras_n;
    logic             cas_n;
    logic [ROW_W-1:0] a;
  } dram_cmd_t;

  localparam dram_cmd_t CMD_IDLE = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, a: '0};

endpackage

// File: rtl/dram_rd_fifo.sv
// Read-data buffer between the DRAM capture point and the output stream.
module dram_rd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dram_burst_reader.sv
// Page-mode sequential DRAM read master returning words in order on a
// valid/ready stream. DRAM pins are registered from the next-state decision.
module dram_burst_reader
  import dram_pkg::*;
#(
  parameter int unsigned TRCD       = 2,
  parameter int unsigned CL         = 2,
  parameter int unsigned TRP        = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  input  logic [31:0]       Q,
  output logic              CSn,
  output logic              RASn,
  output logic              CASn,
  output logic [3:0]        WEn,
  output logic [ROW_W-1:0]  A,
  output logic [31:0]       D
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  rd_state_e         state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              row_end_q, row_end_d;
  logic [CL-1:0]     tag_q, tag_d;
  dram_cmd_t         cmd_q, cmd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cas_q, cas_d;
  logic              push, pop, fifo_empty, credit_ok, drain_ok;
  logic [CNT_W-1:0]  fifo_count;

  assign cas_q = ~cmd_q.cas_n;
  assign push  = tag_q[CL-1];
  assign pop   = out_valid & out_ready;
  assign tag_d = CL'({tag_q, cas_q});

  // Worst case occupancy once every outstanding CAS has landed, net of this cycle's pop.
  assign credit_ok = (int'(fifo_count) + $countones(tag_q) + int'(cas_q) - int'(pop))
                     < int'(FIFO_DEPTH);
  assign drain_ok  = (tag_d == '0) && ((int'(fifo_count) + int'(push) - int'(pop)) == 0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && (length != '0)) state_d = ST_ACT;
      ST_ACT:   state_d = (TRCD > 1) ? ST_RCD : ST_READ;
      ST_RCD:   if (wait_q == WAIT_W'(TRCD - 2)) state_d = ST_READ;
      ST_READ:  if (!cas_q && ((rem_q == '0) || row_end_q)) state_d = ST_PRE;
      ST_PRE: begin
        if (wait_q == WAIT_W'(TRP - 1)) begin
          if (rem_q != '0)   state_d = ST_ACT;
          else if (drain_ok) state_d = ST_IDLE;
          else               state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (drain_ok) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    rem_d     = rem_q;
    row_end_d = row_end_q;
    cmd_d     = cmd_q;
    wait_d    = (state_d != state_q) ? '0 : wait_q + WAIT_W'(1);
    busy_d    = (state_d != ST_IDLE);
    done_d    = ((state_q == ST_IDLE) && start && (length == '0)) ||
                ((state_q != ST_IDLE) && (state_d == ST_IDLE));

    if ((state_q == ST_IDLE) && start && (length != '0)) begin
      row_d = base_addr[ADDR_W-1:COL_W];
      col_d = base_addr[COL_W-1:0];
      rem_d = length;
    end

    cas_d = (state_d == ST_READ) && (rem_q != '0) && !row_end_q && credit_ok;

    if (cas_d) begin
      row_end_d = (col_q == '1);
      col_d     = col_q + COL_W'(1);
      rem_d     = rem_q - ADDR_W'(1);
      if (col_q == '1) row_d = row_q + ROW_W'(1);
    end else if (state_d != ST_READ) begin
      row_end_d = 1'b0;
    end

    cmd_d.cs_n  = !(state_d inside {ST_ACT, ST_RCD, ST_READ, ST_PRE});
    cmd_d.ras_n = !(state_d inside {ST_ACT, ST_RCD, ST_READ});
    cmd_d.cas_n = !cas_d;
    if (state_d == ST_ACT) cmd_d.a = row_d;
    else if (cas_d)        cmd_d.a = ROW_W'(col_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q     <= '0;
      col_q     <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      row_end_q <= 1'b0;
      tag_q     <= '0;
      cmd_q     <= CMD_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      row_end_q <= row_end_d;
      tag_q     <= tag_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  dram_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .wdata_i (Q),
    .pop_i   (pop),
    .rdata_o (out_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign busy      = busy_q;
  assign done      = done_q;
  assign CSn       = cmd_q.cs_n;
  assign RASn      = cmd_q.ras_n;
  assign CASn      = cmd_q.cas_n;
  assign A         = cmd_q.a;
  assign WEn       = 4'hF;
  assign D         = '0;

endmodule

// File: tb/tb_dram_burst_reader.sv
// Directed bench for dram_burst_reader with a CL=2 DRAM data model.
module tb_dram_burst_reader;
  import dram_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [22:0] base_addr, length;
  logic        busy, done, out_valid;
  logic [31:0] out_data;
  logic [31:0] Q = 32'h0;
  logic        CSn, RASn, CASn;
  logic [3:0]  WEn;
  logic [12:0] A;
  logic [31:0] D;

  always #5 clk = ~clk;

  dram_burst_reader #(.TRCD(2), .CL(2), .TRP(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .Q(Q), .CSn(CSn), .RASn(RASn), .CASn(CASn),
    .WEn(WEn), .A(A), .D(D)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and DRAM model; every word read equals its own word address.
  int          cyc = 0;
  int          act_row_q[$], act_cyc_q[$], pre_at_act_q[$];
  int          cas_col_q[$], cas_cyc_q[$], got_cyc_q[$], done_cyc_q[$];
  logic [31:0] got_q[$];
  int          pre_run = 0, cs_low_cnt = 0, busy_cnt = 0, start_cyc = 0;
  logic        prev_ras = 1'b1, done_busy = 1'b1;
  logic [12:0] cur_row = '0;
  logic [31:0] p1 = 32'hdeadbeef, p2 = 32'hdeadbeef;

  always @(negedge clk) begin
    cyc++;
    Q  = p2;
    p2 = p1;
    p1 = 32'hdeadbeef;
    if (!CSn && !RASn && prev_ras) begin
      cur_row = A;
      act_row_q.push_back(int'(A));
      act_cyc_q.push_back(cyc);
      pre_at_act_q.push_back(pre_run);
      pre_run = 0;
    end
    if (!CSn && RASn) pre_run++;
    if (!CSn) cs_low_cnt++;
    if (busy) busy_cnt++;
    if (!CSn && !CASn) begin
      cas_col_q.push_back(int'(A[9:0]));
      cas_cyc_q.push_back(cyc);
      p1 = {9'd0, cur_row, A[9:0]};
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_busy = busy;
    end
    if (start && !busy) start_cyc = cyc;
    prev_ras = RASn;
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic do_start(input logic [22:0] b, input logic [22:0] l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int max);
    int k = 0;
    while (done_cyc_q.size() == d0 && k < max) begin
      @(posedge clk);
      k++;
    end
    chk_eq({tag, "_done_seen"}, 64'(done_cyc_q.size() > d0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_words(input string tag, input int g0, input logic [22:0] b, input int n);
    chk_eq({tag, "_word_count"}, 64'(got_q.size() - g0), 64'(n));
    for (int i = 0; i < n; i++)
      if (g0 + i < got_q.size()) chk_eq({tag, "_word"}, got_q[g0 + i], 64'(b) + 64'(i));
  endtask

  int a0, c0, g0, d0, cs0, b0;

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; length = '0;
    #2 rst = 1'b0;
    #1;
    chk_eq("rst_csn", CSn, 1);      chk_eq("rst_rasn", RASn, 1);
    chk_eq("rst_casn", CASn, 1);    chk_eq("rst_wen", WEn, 4'hF);
    chk_eq("rst_a", A, 0);          chk_eq("rst_d", D, 0);
    chk_eq("rst_busy", busy, 0);    chk_eq("rst_done", done, 0);
    chk_eq("rst_valid", out_valid, 0); chk_eq("rst_data", out_data, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // basic burst
    a0 = act_row_q.size(); c0 = cas_col_q.size(); g0 = got_q.size(); d0 = done_cyc_q.size();
    b0 = busy_cnt;
    do_start(OUTPUT_START, 23'd4);
    wait_done("basic", d0, 60);
    chk_eq("basic_act_row", qat(act_row_q, a0), 13'h600);
    chk_eq("basic_act_lat", qat(act_cyc_q, a0) - start_cyc, 1);
    chk_eq("basic_cas_count", cas_col_q.size() - c0, 4);
    for (int i = 0; i < 4; i++) chk_eq("basic_cas_col", qat(cas_col_q, c0 + i), i);
    chk_eq("basic_trcd", qat(cas_cyc_q, c0) - qat(act_cyc_q, a0), 2);
    chk_eq("basic_cas_b2b", qat(cas_cyc_q, c0 + 3) - qat(cas_cyc_q, c0), 3);
    chk_eq("basic_first_valid", qat(got_cyc_q, g0) - qat(cas_cyc_q, c0), 3);
    check_words("basic", g0, OUTPUT_START, 4);
    chk_eq("basic_done_lat", qat(done_cyc_q, d0) - qat(got_cyc_q, g0 + 3), 1);
    chk_eq("basic_busy_at_done", done_busy, 0);
    chk_eq("basic_busy_len", busy_cnt - b0, qat(done_cyc_q, d0) - start_cyc - 1);

    // row crossing
    a0 = act_row_q.size(); c0 = cas_col_q.size(); g0 = got_q.size(); d0 = done_cyc_q.size();
    do_start(23'h0017FE, 23'd4);
    wait_done("rowx", d0, 80);
    chk_eq("rowx_act0", qat(act_row_q, a0), 5);
    chk_eq("rowx_act1", qat(act_row_q, a0 + 1), 6);
    chk_eq("rowx_pre_cycles", qat(pre_at_act_q, a0 + 1), 2);
    chk_eq("rowx_col0", qat(cas_col_q, c0), 1022);
    chk_eq("rowx_col1", qat(cas_col_q, c0 + 1), 1023);
    chk_eq("rowx_col2", qat(cas_col_q, c0 + 2), 0);
    chk_eq("rowx_col3", qat(cas_col_q, c0 + 3), 1);
    chk_eq("rowx_penalty", qat(cas_cyc_q, c0 + 2) - qat(cas_cyc_q, c0 + 1), 6);
    check_words("rowx", g0, 23'h0017FE, 4);

    // backpressure with a 4-deep FIFO
    out_ready = 1'b0;
    a0 = act_row_q.size(); c0 = cas_col_q.size(); g0 = got_q.size(); d0 = done_cyc_q.size();
    do_start(WEIGHT_START, 23'd10);
    repeat (20) @(posedge clk);
    #1;
    chk_eq("bp_stall_cas", cas_col_q.size() - c0, 4);
    chk_eq("bp_stall_rasn", RASn, 0);
    chk_eq("bp_stall_csn", CSn, 0);
    chk_eq("bp_stall_valid", out_valid, 1);
    chk_eq("bp_stall_busy", busy, 1);
    out_ready = 1'b1;
    wait_done("bp", d0, 200);
    chk_eq("bp_cas_total", cas_col_q.size() - c0, 10);
    chk_eq("bp_act_total", act_row_q.size() - a0, 1);
    check_words("bp", g0, WEIGHT_START, 10);

    // zero length
    a0 = act_row_q.size(); d0 = done_cyc_q.size(); cs0 = cs_low_cnt; b0 = busy_cnt;
    do_start(OUTPUT_START, 23'd0);
    wait_done("zero", d0, 10);
    chk_eq("zero_done_lat", qat(done_cyc_q, d0) - start_cyc, 1);
    chk_eq("zero_cs_quiet", cs_low_cnt - cs0, 0);
    chk_eq("zero_busy_quiet", busy_cnt - b0, 0);
    chk_eq("zero_no_act", act_row_q.size() - a0, 0);

    // reset in the middle of a burst
    c0 = cas_col_q.size();
    do_start(OUTPUT_START + 23'h20, 23'd8);
    for (int k = 0; k < 20 && CASn; k++) begin
      @(posedge clk); #1;
    end
    chk_eq("mid_in_read", CASn, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_eq("mid_rst_csn", CSn, 1);   chk_eq("mid_rst_rasn", RASn, 1);
    chk_eq("mid_rst_casn", CASn, 1); chk_eq("mid_rst_a", A, 0);
    chk_eq("mid_rst_busy", busy, 0); chk_eq("mid_rst_valid", out_valid, 0);
    chk_eq("mid_rst_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    g0 = got_q.size(); d0 = done_cyc_q.size();
    do_start(OUTPUT_START + 23'h40, 23'd2);
    wait_done("post_rst", d0, 60);
    check_words("post_rst", g0, OUTPUT_START + 23'h40, 2);

    // start while busy is ignored
    a0 = act_row_q.size(); g0 = got_q.size(); d0 = done_cyc_q.size();
    do_start(OUTPUT_START + 23'h100, 23'd3);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; base_addr = '0; length = 23'd5;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("busy_start", d0, 60);
    repeat (30) @(posedge clk);
    #1;
    chk_eq("busy_start_dones", done_cyc_q.size() - d0, 1);
    chk_eq("busy_start_acts", act_row_q.size() - a0, 1);
    check_words("busy_start", g0, OUTPUT_START + 23'h100, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
